// File: rtl/info_frame_if.sv
// Handshake and frame bundle between the InfoFrame builder and its
// host (payload writes, commit) and packet picker (swap, header/sub).
interface info_frame_if;
    logic            wr_valid;
    logic            wr_ready;
    logic [4:0]      wr_addr;
    logic [7:0]      wr_data;
    logic            commit;
    logic [4:0]      length;
    logic            swap_ok;
    logic            busy;
    logic            frame_valid;
    logic            error;
    logic [23:0]     header;
    logic [3:0][55:0] sub;

    modport master (
        output wr_valid, wr_addr, wr_data, commit, length, swap_ok,
        input  wr_ready, busy, frame_valid, error, header, sub
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit, length, swap_ok,
        output wr_ready, busy, frame_valid, error, header, sub
    );
endinterface

// File: rtl/info_frame_builder.sv
// Runtime-programmable InfoFrame source: shadow payload buffer, sequential
// checksum, and atomic swap into the active frame seen by the packet picker.
module info_frame_builder #(
    parameter logic [6:0] TYPE       = 7'd3,
    parameter logic [7:0] VERSION    = 8'd1,
    parameter int         MAX_LENGTH = 27
) (
    input  logic        clk_pixel,
    input  logic        reset,
    info_frame_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        WAIT_SWAP
    } state_t;

    localparam logic [4:0] MAX_L = 5'(MAX_LENGTH);

    state_t           state_q;
    logic [4:0]       len_q;
    logic [4:0]       idx_q;
    logic [7:0]       acc_q;
    logic [27:0][7:0] shadow_q;
    logic [27:0][7:0] active_q;
    logic [27:0][7:0] frame_d;
    logic [23:0]      header_q;
    logic             frame_valid_q;
    logic             error_q;

    logic wr_ok;
    logic len_ok;

    assign wr_ok  = (bus.wr_addr >= 5'd1) && (bus.wr_addr <= MAX_L);
    assign len_ok = (bus.length != 5'd0) && (bus.length <= MAX_L);

    // Next active frame: PB0 is the checksum, bytes beyond L are cleared.
    always_comb begin
        frame_d = '0;
        for (int i = 0; i < 28; i++) begin
            frame_d[i] = (5'(i) <= len_q) ? shadow_q[i] : 8'h00;
        end
        frame_d[0] = 8'd0 - acc_q;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            header_q      <= '0;
            frame_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_valid) begin
                        if (wr_ok) shadow_q[bus.wr_addr] <= bus.wr_data;
                        else       error_q <= 1'b1;
                    end
                    if (bus.commit) begin
                        if (!len_ok) begin
                            error_q <= 1'b1;
                        end else begin
                            len_q   <= bus.length;
                            error_q <= 1'b0;
                            acc_q   <= 8'h80 + {1'b0, TYPE} + VERSION
                                       + {3'b000, bus.length};
                            idx_q   <= 5'd1;
                            state_q <= SUM;
                        end
                    end
                end
                SUM: begin
                    acc_q <= acc_q + shadow_q[idx_q];
                    idx_q <= idx_q + 5'd1;
                    if (idx_q == len_q) state_q <= WAIT_SWAP;
                end
                WAIT_SWAP: begin
                    if (bus.swap_ok) begin
                        active_q      <= frame_d;
                        header_q      <= {3'b000, len_q, VERSION, 1'b1, TYPE};
                        frame_valid_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_valid = frame_valid_q;
    assign bus.error       = error_q;
    assign bus.header      = header_q;
    assign bus.sub         = active_q;

endmodule

// File: tb/tb_info_frame_builder.sv
// Self-checking bench for info_frame_builder: directed table, corner
// sequences and randomized builds against a byte-level frame model.
module tb_info_frame_builder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    info_frame_if bus ();
    info_frame_if bus2 ();

    info_frame_builder u_dut (
        .clk_pixel (clk),
        .reset     (rst),
        .bus       (bus)
    );

    info_frame_builder #(.TYPE(7'd2), .VERSION(8'd2)) u_dut2 (
        .clk_pixel (clk),
        .reset     (rst),
        .bus       (bus2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int sh_m [28];
    logic err_m;

    typedef struct {
        bit         we;
        logic [4:0] wa;
        logic [7:0] wd;
        bit         cm;
        logic [4:0] ln;
        bit         exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(string nm, logic [223:0] act, logic [223:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected payload view: checksum makes header+PB0..PBL sum to 0 mod 256.
    function automatic logic [223:0] exp_sub(int len, int ty, int ver);
        logic [223:0] r;
        int s;
        r = '0;
        s = 128 + ty + ver + len;
        for (int i = 1; i <= len; i++) begin
            r[i*8 +: 8] = 8'(sh_m[i]);
            s += sh_m[i];
        end
        r[7:0] = 8'((256 - (s % 256)) % 256);
        return r;
    endfunction

    function automatic logic [23:0] exp_hdr(int len, int ty, int ver);
        return 24'(len * 65536 + ver * 256 + 128 + ty);
    endfunction

    task automatic do_write(logic [4:0] a, logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
        if (a >= 1 && a <= 27) sh_m[a] = d;
        else err_m = 1'b1;
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 224'(bus.busy), 224'(0));
    endtask

    initial begin
        logic [23:0]  hdr_prev;
        logic [223:0] sub_prev;
        logic [223:0] s2;
        int len;
        int dly;
        int nw;

        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.commit = 0; bus.length = 0; bus.swap_ok = 1;
        bus2.wr_valid = 0; bus2.wr_addr = 0; bus2.wr_data = 0;
        bus2.commit = 0; bus2.length = 0; bus2.swap_ok = 1;
        for (int i = 0; i < 28; i++) sh_m[i] = 0;
        err_m = 0;

        tbl[0] = '{1, 5'd0,  8'h11, 0, 5'd0,  1};
        tbl[1] = '{1, 5'd28, 8'h22, 0, 5'd0,  1};
        tbl[2] = '{0, 5'd0,  8'h00, 1, 5'd0,  1};
        tbl[3] = '{0, 5'd0,  8'h00, 1, 5'd28, 1};
        tbl[4] = '{1, 5'd31, 8'h33, 0, 5'd0,  1};
        tbl[5] = '{1, 5'd27, 8'hAA, 0, 5'd0,  1};

        // Reset state
        tick(); tick();
        chk("rst_header", 224'(bus.header), 224'(0));
        chk("rst_sub", bus.sub, '0);
        chk("rst_fv", 224'(bus.frame_valid), 224'(0));
        chk("rst_err", 224'(bus.error), 224'(0));
        chk("rst_busy", 224'(bus.busy), 224'(0));
        chk("rst_ready", 224'(bus.wr_ready), 224'(1));
        rst = 1'b0;
        tick();

        // Length 25, empty shadow, latency check
        bus.commit = 1; bus.length = 5'd25;
        tick();
        bus.commit = 0;
        for (int i = 0; i < 25; i++) tick();
        chk("lat_busy_T25", 224'(bus.busy), 224'(1));
        chk("lat_hdr_T25", 224'(bus.header), 224'(0));
        tick();
        chk("t1_header", 224'(bus.header), 224'(24'h190183));
        chk("t1_pb0", 224'(bus.sub[0][7:0]), 224'(8'h63));
        chk("t1_fv", 224'(bus.frame_valid), 224'(1));
        chk("t1_sub", bus.sub, exp_sub(25, 3, 1));

        // TYPE=2 VERSION=2 instance
        bus2.wr_valid = 1; bus2.wr_addr = 5'd1; bus2.wr_data = 8'h10;
        tick();
        bus2.wr_valid = 0;
        bus2.commit = 1; bus2.length = 5'd13;
        tick();
        bus2.commit = 0;
        for (int i = 0; i < 14; i++) tick();
        s2 = bus2.sub;
        chk("t2_header", 224'(bus2.header), 224'(24'h0D0282));
        chk("t2_pb0", 224'(s2[7:0]), 224'(8'h5F));
        chk("t2_pb1", 224'(s2[15:8]), 224'(8'h10));
        chk("t2_pb14_27", 224'(s2[223:112]), 224'(0));

        // Error table: active buffer must stay untouched
        hdr_prev = bus.header;
        sub_prev = bus.sub;
        foreach (tbl[k]) begin
            bus.wr_valid = tbl[k].we;
            bus.wr_addr  = tbl[k].wa;
            bus.wr_data  = tbl[k].wd;
            bus.commit   = tbl[k].cm;
            bus.length   = tbl[k].ln;
            tick();
            bus.wr_valid = 0; bus.commit = 0;
            if (tbl[k].we && tbl[k].wa >= 1 && tbl[k].wa <= 27)
                sh_m[tbl[k].wa] = tbl[k].wd;
            chk($sformatf("tbl%0d_err", k), 224'(bus.error),
                224'(tbl[k].exp_err));
            chk($sformatf("tbl%0d_busy", k), 224'(bus.busy), 224'(0));
            chk($sformatf("tbl%0d_hdr", k), 224'(bus.header),
                224'(hdr_prev));
        end
        chk("tbl_sub", bus.sub, sub_prev);

        // A valid commit clears the sticky error
        bus.commit = 1; bus.length = 5'd27;
        tick();
        bus.commit = 0;
        chk("clr_err", 224'(bus.error), 224'(0));
        err_m = 0;
        wait_idle("clr");
        chk("clr_header", 224'(bus.header), 224'(exp_hdr(27, 3, 1)));
        chk("clr_sub", bus.sub, exp_sub(27, 3, 1));

        // swap_ok held low: no output change until it rises
        do_write(5'd2, 8'h5A);
        hdr_prev = bus.header;
        sub_prev = bus.sub;
        bus.swap_ok = 0;
        bus.commit = 1; bus.length = 5'd5;
        tick();
        bus.commit = 0;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 50; i++) begin
            chk($sformatf("hold%0d_busy", i), 224'(bus.busy), 224'(1));
            chk($sformatf("hold%0d_rdy", i), 224'(bus.wr_ready), 224'(0));
            chk($sformatf("hold%0d_hdr", i), 224'(bus.header),
                224'(hdr_prev));
            tick();
        end
        chk("hold_sub", bus.sub, sub_prev);
        bus.swap_ok = 1;
        tick();
        chk("hold_swap_hdr", 224'(bus.header), 224'(exp_hdr(5, 3, 1)));
        chk("hold_swap_sub", bus.sub, exp_sub(5, 3, 1));
        chk("hold_swap_busy", 224'(bus.busy), 224'(0));

        // Same-cycle write with commit; writes during SUM are refused
        bus.wr_valid = 1; bus.wr_addr = 5'd5; bus.wr_data = 8'hFF;
        bus.commit = 1; bus.length = 5'd10;
        tick();
        sh_m[5] = 8'hFF;
        bus.commit = 0;
        bus.wr_addr = 5'd3; bus.wr_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sum_rdy%0d", i), 224'(bus.wr_ready), 224'(0));
            tick();
        end
        bus.wr_valid = 0;
        wait_idle("same");
        chk("same_sub", bus.sub, exp_sub(10, 3, 1));
        chk("same_err", 224'(bus.error), 224'(0));

        // Randomized builds
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++)
                do_write(5'($urandom_range(0, 31)), 8'($urandom));
            chk($sformatf("rnd%0d_err", it), 224'(bus.error), 224'(err_m));
            len = $urandom_range(1, 27);
            dly = $urandom_range(0, 5);
            bus.swap_ok = 0;
            bus.commit = 1; bus.length = 5'(len);
            tick();
            bus.commit = 0;
            err_m = 0;
            for (int i = 0; i < len + dly; i++) tick();
            chk($sformatf("rnd%0d_busy", it), 224'(bus.busy), 224'(1));
            bus.swap_ok = 1;
            wait_idle($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_hdr", it), 224'(bus.header),
                224'(exp_hdr(len, 3, 1)));
            chk($sformatf("rnd%0d_sub", it), bus.sub, exp_sub(len, 3, 1));
            chk($sformatf("rnd%0d_fv", it), 224'(bus.frame_valid), 224'(1));
        end

        // Reset during SUM aborts the build and clears outputs at once
        bus.commit = 1; bus.length = 5'd20;
        tick();
        bus.commit = 0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_header", 224'(bus.header), 224'(0));
        chk("arst_sub", bus.sub, '0);
        chk("arst_fv", 224'(bus.frame_valid), 224'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("arst_ready", 224'(bus.wr_ready), 224'(1));
        chk("arst_busy", 224'(bus.busy), 224'(0));
        for (int i = 0; i < 28; i++) sh_m[i] = 0;
        bus.commit = 1; bus.length = 5'd4;
        tick();
        bus.commit = 0;
        wait_idle("post_rst");
        chk("post_rst_sub", bus.sub, exp_sub(4, 3, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/info_frame_builder.md
Name: info_frame_builder

Overview:
Runtime-programmable InfoFrame packet source for any InfoFrame type (SPD, AVI, audio, vendor-specific).
- Payload bytes PB1..PBn are written at runtime into a shadow buffer instead of being fixed by parameters.
- The block computes the CEA-861 checksum sequentially, one byte per cycle.
- It swaps the completed frame atomically into an active buffer, which drives header/sub to the packet picker.

Parameters:
TYPE, 7'd3, InfoFrame type code; header byte HB0 = {1'b1, TYPE}.
VERSION, 8'd1, InfoFrame version, driven on HB1.
MAX_LENGTH, 27, largest accepted payload length in bytes (1..27).

Ports:
clk_pixel  input  1  pixel clock; all state is on its rising edge.
reset  input  1  asynchronous, active-high reset.
wr_valid  input  1  payload write request.
wr_ready  output  1  high when writes and commit are accepted (state IDLE).
wr_addr  input  5  payload byte index, 1..27.
wr_data  input  8  payload byte value.
commit  input  1  single-cycle pulse: build a frame from the shadow buffer.
length  input  5  payload length, sampled on an accepted commit.
swap_ok  input  1  packet picker is not mid-transmission, so the active buffer may change.
busy  output  1  high in SUM or WAIT_SWAP.
frame_valid  output  1  active buffer holds a committed frame.
error  output  1  sticky error flag; cleared on the next accepted, valid commit.
header  output  24  {HB2, HB1, HB0} of the active frame.
sub  output  4x56  sub[i] = {PB(7i+6), ..., PB(7i)}, PB0 in the LSB of sub[0].

Behaviour:
- Reset (asynchronous, while asserted):
  - state = IDLE; shadow bytes, active bytes, header and sub all 0.
  - frame_valid = 0, error = 0, busy = 0, wr_ready = 1.
- Reset asserted mid-SUM or mid-WAIT_SWAP aborts the build; no partial frame ever reaches the active buffer.
- Writes:
  - Accepted when wr_valid && wr_ready.
  - If 1 <= wr_addr <= MAX_LENGTH, shadow[wr_addr] <= wr_data on that edge.
  - Otherwise the write is consumed but dropped, and error <= 1.
- Commit:
  - Accepted only in IDLE.
  - If length == 0 or length > MAX_LENGTH: error <= 1 and state stays IDLE.
  - Otherwise: latch length into L, error <= 0, acc <= 8'h80 + TYPE + VERSION + L (mod 256), idx <= 1, go to SUM.
- Same-cycle write + commit in IDLE: the write lands first and is included in the checksum.
- commit or wr_valid outside IDLE: ignored, with no error.
- SUM state:
  - Each cycle: acc <= acc + shadow[idx], idx <= idx + 1.
  - After idx == L is summed, go to WAIT_SWAP. SUM lasts exactly L cycles.
  - Shadow is frozen during SUM because wr_ready = 0.
- WAIT_SWAP state:
  - Holds with busy = 1 until swap_ok is high.
  - On the first edge with swap_ok = 1:
    - active PB0 <= (8'd0 - acc), two's complement, so HB0+HB1+HB2+PB0..PBL sum to 0 mod 256.
    - active PB1..PBL <= shadow; PB(L+1)..PB27 <= 0.
    - header <= {3'b0, L, VERSION, 1'b1, TYPE}.
    - frame_valid <= 1; state <= IDLE.
- Latency: commit accepted at edge T → SUM on edges T+1..T+L → WAIT_SWAP from T+L. If swap_ok is already high, the new header/sub are visible after edge T+L+1.
- Outputs change only on the swap edge, so header and sub are never a mix of two frames.
- The shadow buffer is not cleared by a commit; stale bytes persist for the next build.

Test Plan:
- Reset, then commit with length = 25, TYPE = 3, VERSION = 1, shadow all 0, swap_ok = 1 → after 26 edges: header = 24'h190183, PB0 = 8'h63, frame_valid = 1.
- TYPE = 2, VERSION = 2: write PB1 = 8'h10, commit length = 13 → header = 24'h0D0282, PB0 = 8'h5F, sub[0][15:8] = 8'h10, PB14..PB27 = 0.
- Hold swap_ok = 0 for 50 cycles after SUM → busy = 1, wr_ready = 0, header/sub unchanged; raise swap_ok → update on the next edge.
- Commit length = 0, write wr_addr = 0, write wr_addr = 28 → error = 1 each time, state stays IDLE, active buffer untouched; a following valid commit clears error.
- Same-cycle write PB5 = 8'hFF with commit → checksum includes 8'hFF; writes attempted during SUM are not accepted, and shadow and checksum are unaffected.
- Assert reset at SUM cycle 3 → header = 0, sub = 0, frame_valid = 0 immediately; after release wr_ready = 1.
